// File: rtl/line_drawer_core.sv
// Bresenham line rasterizer: an FSM controller strobes a register/arithmetic
// datapath to emit one pixel per clock between two 11-bit endpoints.

module line_drawer_control (
    input  logic clk,
    input  logic reset,
    input  logic at_end,
    input  logic err_ge0,
    output logic load_reg,
    output logic prep_reg,
    output logic plot,
    output logic incr_x,
    output logic incr_y,
    output logic done
);
    typedef enum logic [1:0] {S_LOAD, S_DRAW, S_DONE} state_t;

    state_t state, state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_DONE)
                done <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        load_reg   = reset;
        prep_reg   = 1'b0;
        plot       = 1'b0;
        incr_x     = 1'b0;
        incr_y     = 1'b0;
        case (state)
            S_LOAD: begin
                prep_reg   = 1'b1;
                state_next = S_DRAW;
            end
            S_DRAW: begin
                plot = 1'b1;
                // The final pixel is plotted but the cursor is left in place.
                if (at_end) begin
                    state_next = S_DONE;
                end else begin
                    incr_x = 1'b1;
                    incr_y = err_ge0;
                end
            end
            S_DONE:  state_next = S_DONE;
            default: state_next = S_LOAD;
        endcase
    end
endmodule

module line_drawer_datapath (
    input  logic        clk,
    input  logic [10:0] x0,
    input  logic [10:0] y0,
    input  logic [10:0] x1,
    input  logic [10:0] y1,
    input  logic        load_reg,
    input  logic        prep_reg,
    input  logic        plot,
    input  logic        incr_x,
    input  logic        incr_y,
    output logic        at_end,
    output logic        err_ge0,
    output logic [10:0] x,
    output logic [10:0] y
);
    logic [10:0] ix0, iy0, ix1, iy1;
    logic [10:0] adx, ady;
    logic        steep;
    logic [10:0] sx0, sy0, sx1, sy1;
    logic [10:0] nx0, ny0, nx1, ny1;
    logic [10:0] dx_n, dy_n;
    logic signed [11:0] err_init;

    logic        steep_r, ystep_neg;
    logic [10:0] xend, deltax, deltay, cx, cy;
    logic signed [11:0] err_r, e_next;

    // Setup: fold the line into the shallow, left-to-right octant pair.
    always_comb begin
        adx   = (ix1 >= ix0) ? ix1 - ix0 : ix0 - ix1;
        ady   = (iy1 >= iy0) ? iy1 - iy0 : iy0 - iy1;
        steep = ady > adx;
        sx0   = steep ? iy0 : ix0;
        sy0   = steep ? ix0 : iy0;
        sx1   = steep ? iy1 : ix1;
        sy1   = steep ? ix1 : iy1;
        if (sx0 > sx1) begin
            nx0 = sx1; ny0 = sy1; nx1 = sx0; ny1 = sy0;
        end else begin
            nx0 = sx0; ny0 = sy0; nx1 = sx1; ny1 = sy1;
        end
        dx_n     = nx1 - nx0;
        dy_n     = (ny1 >= ny0) ? ny1 - ny0 : ny0 - ny1;
        err_init = -$signed({2'b00, dx_n[10:1]});
    end

    always_comb begin
        e_next  = err_r + $signed({1'b0, deltay});
        err_ge0 = ~e_next[11];
        at_end  = (cx == xend);
    end

    always_ff @(posedge clk) begin
        if (load_reg) begin
            ix0 <= x0;
            iy0 <= y0;
            ix1 <= x1;
            iy1 <= y1;
            x   <= 11'd0;
            y   <= 11'd0;
        end else begin
            if (prep_reg) begin
                steep_r   <= steep;
                xend      <= nx1;
                deltax    <= dx_n;
                deltay    <= dy_n;
                ystep_neg <= !(ny0 < ny1);
                err_r     <= err_init;
                cx        <= nx0;
                cy        <= ny0;
            end
            if (plot) begin
                x <= steep_r ? cy : cx;
                y <= steep_r ? cx : cy;
            end
            if (incr_x) begin
                cx <= cx + 11'd1;
                if (incr_y) begin
                    cy    <= ystep_neg ? cy - 11'd1 : cy + 11'd1;
                    err_r <= e_next - $signed({1'b0, deltax});
                end else begin
                    err_r <= e_next;
                end
            end
        end
    end
endmodule

module line_drawer_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x0,
    input  logic [10:0] y0,
    input  logic [10:0] x1,
    input  logic [10:0] y1,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        done
);
    logic load_reg, prep_reg, plot, incr_x, incr_y, at_end, err_ge0;

    line_drawer_control u_control (
        .clk      (clk),
        .reset    (reset),
        .at_end   (at_end),
        .err_ge0  (err_ge0),
        .load_reg (load_reg),
        .prep_reg (prep_reg),
        .plot     (plot),
        .incr_x   (incr_x),
        .incr_y   (incr_y),
        .done     (done)
    );

    line_drawer_datapath u_datapath (
        .clk      (clk),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .load_reg (load_reg),
        .prep_reg (prep_reg),
        .plot     (plot),
        .incr_x   (incr_x),
        .incr_y   (incr_y),
        .at_end   (at_end),
        .err_ge0  (err_ge0),
        .x        (x),
        .y        (y)
    );
endmodule

// File: tb/tb_line_drawer_core.sv
// Directed testbench for line_drawer_core: checks every pixel and the done
// timing of the lines in the test plan, plus reset behaviour.

module tb_line_drawer_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [10:0] x, y;
    logic        done;

    int tests = 0;
    int fails = 0;

    line_drawer_core dut (
        .clk   (clk),
        .reset (reset),
        .x0    (x0),
        .y0    (y0),
        .x1    (x1),
        .y1    (y1),
        .x     (x),
        .y     (y),
        .done  (done)
    );

    always #10 clk = ~clk;

    // Reset edge latches the endpoints; inputs are then scrambled (they must be
    // ignored) and the task returns 1 time unit after edge T0.
    task automatic start_line(input int a, input int b, input int c, input int d);
        @(negedge clk);
        reset = 1'b1;
        x0 = 11'(a); y0 = 11'(b); x1 = 11'(c); y1 = 11'(d);
        @(negedge clk);
        reset = 1'b0;
        x0 = 11'h5A5; y0 = 11'h2C3; x1 = 11'h7FF; y1 = 11'h001;
        @(posedge clk);
        #1;
        tests++;
        if (x !== 11'd0 || y !== 11'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL t0_zero (%0d,%0d)->(%0d,%0d): got x=%0d y=%0d done=%b, want 0 0 0",
                     a, b, c, d, x, y, done);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        x0 = 11'd100; y0 = 11'd100; x1 = 11'd200; y1 = 11'd50;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (x !== 11'd0 || y !== 11'd0 || done !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got x=%0d y=%0d done=%b, want 0 0 0", i, x, y, done);
            end
            @(negedge clk);
            x0 = 11'd9; y0 = 11'd4; x1 = 11'd9; y1 = 11'd4;
        end
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if (x !== 11'd9 || y !== 11'd4 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_last_sample: got (%0d,%0d) done=%b, want (9,4) 0", x, y, done);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || x !== 11'd9 || y !== 11'd4) begin
            fails++;
            $display("FAIL reset_last_done: got (%0d,%0d) done=%b, want (9,4) 1", x, y, done);
        end
    endtask

    task automatic test_horizontal;
        int ends [4] = '{0, 10, 10, 0};
        for (int r = 0; r < 2; r++) begin
            start_line(ends[2*r], 0, ends[2*r+1], 0);
            for (int k = 0; k <= 10; k++) begin
                @(posedge clk);
                #1;
                tests++;
                if (x !== 11'(k) || y !== 11'd0 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL horiz%0d px%0d: got (%0d,%0d) done=%b, want (%0d,0) 0",
                             r, k, x, y, done, k);
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b1 || x !== 11'd10 || y !== 11'd0) begin
                fails++;
                $display("FAIL horiz%0d done: got (%0d,%0d) done=%b, want (10,0) 1", r, x, y, done);
            end
        end
    endtask

    task automatic test_shallow;
        int ey [11] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
        for (int r = 0; r < 2; r++) begin
            if (r == 0) start_line(0, 0, 10, 5);
            else        start_line(10, 5, 0, 0);
            for (int k = 0; k <= 10; k++) begin
                @(posedge clk);
                #1;
                tests++;
                if (x !== 11'(k) || y !== 11'(ey[k]) || done !== 1'b0) begin
                    fails++;
                    $display("FAIL shallow%0d px%0d: got (%0d,%0d) done=%b, want (%0d,%0d) 0",
                             r, k, x, y, done, k, ey[k]);
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b1) begin
                fails++;
                $display("FAIL shallow%0d done: got %b, want 1", r, done);
            end
        end
    endtask

    task automatic test_steep;
        int ex [11] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
        start_line(0, 0, 5, 10);
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (x !== 11'(ex[k]) || y !== 11'(k) || done !== 1'b0) begin
                fails++;
                $display("FAIL steep px%0d: got (%0d,%0d) done=%b, want (%0d,%0d) 0",
                         k, x, y, done, ex[k], k);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || x !== 11'd5 || y !== 11'd10) begin
            fails++;
            $display("FAIL steep done: got (%0d,%0d) done=%b, want (5,10) 1", x, y, done);
        end
    endtask

    task automatic test_diag_and_vertical;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) start_line(10, 10, 0, 0);
            else        start_line(0, 10, 0, 0);
            for (int k = 0; k <= 10; k++) begin
                @(posedge clk);
                #1;
                tests++;
                if (x !== 11'(r == 0 ? k : 0) || y !== 11'(k) || done !== 1'b0) begin
                    fails++;
                    $display("FAIL %s px%0d: got (%0d,%0d) done=%b, want (%0d,%0d) 0",
                             r == 0 ? "diag" : "vert", k, x, y, done, r == 0 ? k : 0, k);
                end
            end
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b1) begin
                fails++;
                $display("FAIL %s done: got %b, want 1", r == 0 ? "diag" : "vert", done);
            end
        end
    endtask

    task automatic test_negative_slope;
        int prev_y = 200;
        int decs = 0;
        start_line(0, 200, 50, 190);
        for (int k = 0; k <= 50; k++) begin
            @(posedge clk);
            #1;
            tests++;
            if (x !== 11'(k) || int'(y) > prev_y || int'(y) < prev_y - 1 || done !== 1'b0
                || (k == 0 && y !== 11'd200)) begin
                fails++;
                $display("FAIL negslope px%0d: got (%0d,%0d) done=%b, want x=%0d y in [%0d,%0d] 0",
                         k, x, y, done, k, prev_y - 1, prev_y);
            end
            if (int'(y) < prev_y) decs++;
            prev_y = int'(y);
        end
        tests++;
        if (decs != 10 || y !== 11'd190) begin
            fails++;
            $display("FAIL negslope decrements: got %0d (final y=%0d), want 10 (190)", decs, y);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL negslope done: got %b, want 1", done);
        end
    endtask

    task automatic test_single_point;
        start_line(7, 7, 7, 7);
        @(posedge clk);
        #1;
        tests++;
        if (x !== 11'd7 || y !== 11'd7 || done !== 1'b0) begin
            fails++;
            $display("FAIL single_px: got (%0d,%0d) done=%b, want (7,7) 0", x, y, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b1 || x !== 11'd7 || y !== 11'd7) begin
                fails++;
                $display("FAIL single_done[%0d]: got (%0d,%0d) done=%b, want (7,7) 1", i, x, y, done);
            end
        end
    endtask

    task automatic test_reset_mid_line;
        start_line(0, 0, 10, 0);
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (x !== 11'd3 || y !== 11'd0) begin
            fails++;
            $display("FAIL midline_t4: got (%0d,%0d), want (3,0)", x, y);
        end
        @(negedge clk);
        reset = 1'b1;
        x0 = 11'd3; y0 = 11'd3; x1 = 11'd3; y1 = 11'd3;
        @(posedge clk);
        #1;
        tests++;
        if (x !== 11'd0 || y !== 11'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midline_reset: got (%0d,%0d) done=%b, want (0,0) 0", x, y, done);
        end
        @(negedge clk);
        reset = 1'b0;
        x0 = 11'd0; y0 = 11'd0; x1 = 11'd10; y1 = 11'd0;
        @(posedge clk);
        #1;
        tests++;
        if (x !== 11'd0 || y !== 11'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midline_t0: got (%0d,%0d) done=%b, want (0,0) 0", x, y, done);
        end
        @(posedge clk);
        #1;
        tests++;
        if (x !== 11'd3 || y !== 11'd3 || done !== 1'b0) begin
            fails++;
            $display("FAIL midline_t1: got (%0d,%0d) done=%b, want (3,3) 0", x, y, done);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || x !== 11'd3 || y !== 11'd3) begin
            fails++;
            $display("FAIL midline_t2: got (%0d,%0d) done=%b, want (3,3) 1", x, y, done);
        end
    endtask

    initial begin
        test_reset;
        test_horizontal;
        test_shallow;
        test_steep;
        test_diag_and_vertical;
        test_negative_slope;
        test_single_point;
        test_reset_mid_line;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
